// File: rtl/router_out_port_pkg.sv
// rtl/router_out_port_pkg.sv - shared router constants, header field layout and packet FSM states
// Contents: BYTE_W, header field positions (LEN_MSB/LEN_LSB/ADDR_W), DEFAULT_TIMEOUT,
//           pkt_state_e (HDR, BODY), hdr_len() header length extractor.
package router_out_port_pkg;

   localparam int BYTE_W          = 8;
   localparam int ADDR_W          = 2;
   localparam int LEN_MSB         = 7;
   localparam int LEN_LSB         = ADDR_W;
   localparam int LEN_W           = LEN_MSB - LEN_LSB + 1;
   localparam int DEFAULT_TIMEOUT = 30;

   typedef enum logic [0:0] {
      PKT_HDR  = 1'b0,
      PKT_BODY = 1'b1
   } pkt_state_e;

   function automatic logic [LEN_W-1:0] hdr_len(input logic [BYTE_W-1:0] hdr);
      return hdr[LEN_MSB:LEN_LSB];
   endfunction

endpackage

// File: rtl/router_out_skid.sv
// rtl/router_out_skid.sv - two-entry output buffer between the FIFO read port and the destination
// Ports: i_clock, i_reset (async, active-high), i_clear (sync flush), i_push/i_push_data (byte in),
//        i_pop (head consumed), o_occ (0..2 entries held), o_head (registered head byte).
module router_out_skid
   import router_out_port_pkg::*;
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_clear,
   input  logic              i_push,
   input  logic [BYTE_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [1:0]        o_occ,
   output logic [BYTE_W-1:0] o_head
);

   logic [1:0]        r_occ;
   logic [BYTE_W-1:0] r_head;
   logic [BYTE_W-1:0] r_tail;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_occ  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else if (i_clear) begin
         r_occ  <= 2'd0;
         r_head <= '0;
         r_tail <= '0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_head <= i_push_data;
               else               r_tail <= i_push_data;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_head <= r_tail;
               r_occ  <= r_occ - 2'd1;
            end
            2'b11: begin
               // Occupancy stays put; the new byte lands behind whatever remains.
               if (r_occ == 2'd1) begin
                  r_head <= i_push_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_occ  = r_occ;
   assign o_head = r_head;

endmodule

// File: rtl/router_out_port.sv
// rtl/router_out_port.sv - output-side drain controller for one router destination port
// Ports: i_clock, i_reset (async, active-high); FIFO side i_fifo_empty, i_fifo_data,
//        o_fifo_rd_en (comb), o_fifo_soft_reset (registered pulse); destination side
//        i_dst_read_enb, o_vld_out, o_data_out; status o_pkt_done, o_parity_err, o_pkt_drop.
module router_out_port
   import router_out_port_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_fifo_empty,
   input  logic [BYTE_W-1:0] i_fifo_data,
   output logic              o_fifo_rd_en,
   output logic              o_fifo_soft_reset,
   input  logic              i_dst_read_enb,
   output logic              o_vld_out,
   output logic [BYTE_W-1:0] o_data_out,
   output logic              o_pkt_done,
   output logic              o_parity_err,
   output logic              o_pkt_drop
);

   localparam int              CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [0:0]      S_HDR    = PKT_HDR;
   localparam logic [0:0]      S_BODY   = PKT_BODY;

   logic [1:0]        w_occ;
   logic [BYTE_W-1:0] w_head;
   logic              w_vld;
   logic              w_xfer;
   logic [2:0]        w_level;
   logic              w_rd_en;
   logic              w_timeout;

   logic              r_inflight;
   logic              r_soft_reset;
   logic [CNT_W-1:0]  r_cnt;
   logic [0:0]        r_state;
   logic [6:0]        r_rem;
   logic [BYTE_W-1:0] r_xor;
   logic              r_pkt_done;
   logic              r_parity_err;

   router_out_skid u_skid (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_clear     (w_timeout),
      .i_push      (r_inflight),
      .i_push_data (i_fifo_data),
      .i_pop       (w_xfer),
      .o_occ       (w_occ),
      .o_head      (w_head)
   );

   assign w_vld  = (w_occ != 2'd0);
   assign w_xfer = w_vld && i_dst_read_enb;

   // Occupancy counts the head leaving this cycle as already gone; without that
   // the steady state (one held, one in flight) would stall every third cycle.
   assign w_level   = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_xfer};
   assign w_rd_en   = !i_fifo_empty && (w_level < 3'd2) && !r_soft_reset;
   assign w_timeout = w_vld && !i_dst_read_enb && (r_cnt == CNT_LAST);

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_inflight   <= 1'b0;
         r_soft_reset <= 1'b0;
         r_cnt        <= '0;
      end else begin
         r_soft_reset <= w_timeout;
         if (w_timeout) begin
            // A read issued this cycle is dropped: the FIFO is being cleared anyway.
            r_inflight <= 1'b0;
            r_cnt      <= '0;
         end else begin
            r_inflight <= w_rd_en;
            if (!w_vld || w_xfer) r_cnt <= '0;
            else                  r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_HDR;
         r_rem        <= 7'd0;
         r_xor        <= '0;
         r_pkt_done   <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         r_pkt_done <= 1'b0;
         if (w_timeout) begin
            r_state <= S_HDR;
            r_rem   <= 7'd0;
            r_xor   <= '0;
         end else if (w_xfer) begin
            if (r_state == S_HDR) begin
               // rem counts payload plus the trailing parity byte.
               r_rem   <= {1'b0, hdr_len(w_head)} + 7'd1;
               r_xor   <= w_head;
               r_state <= S_BODY;
            end else if (r_rem == 7'd1) begin
               r_parity_err <= (r_xor != w_head);
               r_pkt_done   <= 1'b1;
               r_state      <= S_HDR;
            end else begin
               r_xor <= r_xor ^ w_head;
               r_rem <= r_rem - 7'd1;
            end
         end
      end
   end

   assign o_fifo_rd_en      = w_rd_en;
   assign o_fifo_soft_reset = r_soft_reset;
   assign o_pkt_drop        = r_soft_reset;
   assign o_vld_out         = w_vld;
   assign o_data_out        = w_head;
   assign o_pkt_done        = r_pkt_done;
   assign o_parity_err      = r_parity_err;

endmodule
